// File: rtl/trajectory_pkg.sv
// Shared types and constants for the trajectory result transmitter:
// FSM state encoding, default header bytes, frame length and the
// byte-selection helper used to serialise one captured sample.
package trajectory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_HI,
    ST_WAIT_LO
  } tx_state_t;

  localparam logic [7:0] HDR_DATA_DEFAULT = 8'hA5;
  localparam logic [7:0] HDR_LAST_DEFAULT = 8'hAE;

  localparam int         FRAME_BYTES = 6;
  localparam int         IDX_W       = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  // Byte 'idx' of a frame: header, x hi, x lo, y hi, y lo, checksum.
  // The checksum covers only the four coordinate bytes.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input logic [15:0]      x,
                                            input logic [15:0]      y,
                                            input logic [7:0]       hdr);
    logic [7:0] csum;
    csum = x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0];
    case (idx)
      3'd0:    return hdr;
      3'd1:    return x[15:8];
      3'd2:    return x[7:0];
      3'd3:    return y[15:8];
      3'd4:    return y[7:0];
      default: return csum;
    endcase
  endfunction

endpackage

// File: rtl/trajectory_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Both flops reset to 0 so the downstream logic sees "no acknowledge".
module trajectory_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw level through two flops; only r_sync is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values,
      // so this is a true two-stage shift and not a single wire.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/trajectory_result_tx.sv
// Serialises trajectory samples (x, y, last) into six-byte frames sent to an
// external host over a four-phase req/ack byte handshake. One sample is held
// at a time; the core is stalled via s_ready while a frame is in flight.
module trajectory_result_tx
  import trajectory_pkg::*;
#(
  parameter logic [7:0] HDR_DATA = HDR_DATA_DEFAULT,
  parameter logic [7:0] HDR_LAST = HDR_LAST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s_x,
  input  logic [15:0] s_y,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ack,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  logic             w_ack_s;
  logic [7:0]       w_hdr_in;
  logic [7:0]       w_hdr_cap;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [7:0]       w_next_byte;
  logic             w_last_byte;

  tx_state_t        r_state;
  logic [15:0]      r_x;
  logic [15:0]      r_y;
  logic             r_last;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic [7:0]       r_frame_cnt;

  // The host acknowledge is asynchronous; never look at tx_ack directly.
  trajectory_sync2 u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (tx_ack),
    .o_q   (w_ack_s)
  );

  // Header for a sample being accepted now, and for the captured sample.
  assign w_hdr_in  = s_last ? HDR_LAST : HDR_DATA;
  assign w_hdr_cap = r_last ? HDR_LAST : HDR_DATA;

  // Next byte of the frame, loaded when the current byte's handshake closes.
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_next_byte = frame_byte(w_idx_nxt, r_x, r_y, w_hdr_cap);
  assign w_last_byte = (r_idx == LAST_IDX);

  // Handshake FSM with registered tx outputs. The first byte is loaded on the
  // capture edge so tx_valid rises the cycle after the sample is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_last      <= 1'b0;
      r_idx       <= '0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_frame_cnt <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            r_x        <= s_x;
            r_y        <= s_y;
            r_last     <= s_last;
            r_idx      <= '0;
            r_tx_data  <= w_hdr_in;
            r_tx_valid <= 1'b1;
            r_state    <= ST_REQ;
          end
        end

        // Request is already on the pins; give the host one full cycle.
        ST_REQ: begin
          r_state <= ST_WAIT_HI;
        end

        // An ack that is already high on entry closes this phase at once.
        ST_WAIT_HI: begin
          if (w_ack_s) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_WAIT_LO;
          end
        end

        // Wait for the host to release ack before moving to the next byte.
        ST_WAIT_LO: begin
          if (!w_ack_s) begin
            if (w_last_byte) begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_tx_data   <= 8'h00;
              r_state     <= ST_IDLE;
            end else begin
              r_idx      <= w_idx_nxt;
              r_tx_data  <= w_next_byte;
              r_tx_valid <= 1'b1;
              r_state    <= ST_REQ;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready   = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign frame_cnt = r_frame_cnt;

endmodule
